// File: rtl/div_8x4_seq_if.sv
// Request/result bundle for the 8-by-4 sequential divider.
// The master issues start with operands; the slave returns results and status.
interface div_8x4_seq_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/div_8x4_seq.sv
// Unsigned 8-bit / 4-bit restoring divider, one quotient bit per cycle, MSB first.
// A zero divisor short-circuits to DONE with quotient all-ones and remainder = dividend[3:0].
module div_8x4_seq (
  input  logic           clk,
  input  logic           rst,
  div_8x4_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q,   cnt_d;
  logic [3:0] p_q,     p_d;
  logic [7:0] dvd_q,   dvd_d;
  logic [3:0] dvs_q,   dvs_d;
  logic [7:0] qacc_q,  qacc_d;
  logic [7:0] quo_q,   quo_d;
  logic [3:0] rem_q,   rem_d;
  logic       dbz_q,   dbz_d;

  // The stored partial remainder is always below the divisor, so the 5-bit
  // P = {p, next bit} is formed here and only its low nibble is kept.
  logic [4:0] trial;
  logic       ge;
  logic [3:0] diff;

  assign trial = {p_q, dvd_q[7]};
  assign ge    = (trial >= {1'b0, dvs_q});
  assign diff  = trial[3:0] - dvs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qacc_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qacc_q  <= qacc_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    qacc_d  = qacc_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d  = bus.dividend;
          dvs_d  = bus.divisor;
          p_d    = '0;
          cnt_d  = '0;
          qacc_d = '0;
          if (bus.divisor == 4'd0) begin
            state_d = DONE;
            quo_d   = 8'hFF;
            rem_d   = bus.dividend[3:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p_d    = ge ? diff : trial[3:0];
        dvd_d  = {dvd_q[6:0], 1'b0};
        qacc_d = {qacc_q[6:0], ge};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          quo_d   = {qacc_q[6:0], ge};
          rem_d   = ge ? diff : trial[3:0];
          dbz_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);

endmodule

// File: tb/tb_div_8x4_seq.sv
// Directed and exhaustive checks for div_8x4_seq: latency, results, divide-by-zero,
// ignored starts, asynchronous reset abort and back-to-back operation.
module tb_div_8x4_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_8x4_seq_if bus ();

  div_8x4_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [7:0] a;
    logic [3:0] d;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    int         bcnt;
  } vec_t;

  vec_t vecs[7];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation from IDLE and wait (bounded) for done; returns in the done cycle.
  task automatic run_op(input logic [7:0] a, input logic [3:0] d, input bit hold,
                        output logic [7:0] q, output logic [3:0] r, output logic z,
                        output int lat, output int bcnt);
    bus.dividend = a;
    bus.divisor  = d;
    bus.start    = 1'b1;
    step();
    if (!hold) bus.start = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = ~d;
    lat  = 1;
    bcnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) bcnt++;
      step();
      lat++;
    end
    if (!bus.done) lat = -1;
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
  endtask

  logic [7:0] q;
  logic [3:0] r;
  logic       z;
  int         lat, bcnt, ndone, dcyc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0, 9, 8};
    vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 9, 8};
    vecs[2] = '{8'd13,  4'd15, 8'd0,   4'd13, 1'b0, 9, 8};
    vecs[3] = '{8'd0,   4'd9,  8'd0,   4'd0,  1'b0, 9, 8};
    vecs[4] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 9, 8};
    vecs[5] = '{8'hA5,  4'd0,  8'hFF,  4'h5,  1'b1, 1, 0};
    vecs[6] = '{8'd10,  4'd3,  8'd3,   4'd1,  1'b0, 9, 8};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #1;
    chk("reset_outputs", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero}, 0);
    bus.start = 1'b1;
    bus.divisor = 4'd3;
    step(); step();
    chk("reset_held_idle", {bus.busy, bus.done, bus.quotient}, 0);
    bus.start = 1'b0;
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].d, 1'b0, q, r, z, lat, bcnt);
      chk($sformatf("v%0d_quotient", i), q, vecs[i].q);
      chk($sformatf("v%0d_remainder", i), r, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), z, vecs[i].z);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].bcnt);
      repeat (3) step();
      chk($sformatf("v%0d_hold", i), {bus.done, bus.busy, bus.quotient, bus.remainder, bus.div_by_zero},
          {2'b00, vecs[i].q, vecs[i].r, vecs[i].z});
    end

    // start re-asserted with new operands in cycle 4 must not disturb 100/6
    bus.dividend = 8'd100; bus.divisor = 4'd6; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd5;
    step();
    bus.start = 1'b0;
    ndone = 0; dcyc = -1; q = '0; r = '0;
    for (int c = 5; c < 20; c++) begin
      if (bus.done) begin
        ndone++;
        dcyc = c;
        q = bus.quotient;
        r = bus.remainder;
      end
      step();
    end
    chk("ignore_start_done_count", ndone, 1);
    chk("ignore_start_done_cycle", dcyc, 9);
    chk("ignore_start_quotient", q, 16);
    chk("ignore_start_remainder", r, 4);

    // asynchronous reset in the middle of cycle 5 aborts the operation
    bus.dividend = 8'd100; bus.divisor = 4'd6; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero}, 0);
    step();
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.done) ndone++;
      step();
    end
    chk("async_reset_no_done", ndone, 0);
    run_op(8'd77, 4'd8, 1'b0, q, r, z, lat, bcnt);
    chk("after_reset_result", {q, r, z}, {8'd9, 4'd5, 1'b0});
    chk("after_reset_latency", lat, 9);
    step();

    // every operand pair back-to-back with start held high
    for (int a = 0; a < 256; a++) begin
      for (int d = 0; d < 16; d++) begin
        logic [7:0] eq;
        logic [3:0] er;
        logic       ez;
        int         el;
        if (d == 0) begin
          eq = 8'hFF; er = a[3:0]; ez = 1'b1; el = 1;
        end else begin
          eq = 8'(a / d); er = 4'(a % d); ez = 1'b0; el = 9;
        end
        run_op(8'(a), 4'(d), 1'b1, q, r, z, lat, bcnt);
        chk($sformatf("exh_%0d_%0d", a, d), {q, r, z, 8'(lat)}, {eq, er, ez, 8'(el)});
        step();
      end
    end
    bus.start = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
